cascade_timer_ctrl: RTL
=======================

Name: cascade_timer_ctrl

Overview:
Command-driven controller that sequences a two-stage cascaded counter: a prescaler stage feeding a main period stage. Accepts LOAD/START/STOP/CLEAR commands over a valid/ready handshake. Issues tick and expire pulses, in one-shot or periodic mode. Serves as the shared timebase controller for test and bring-up logic.

Parameters:
PRE_W, 5, prescaler width; tick period is prescale+1 cycles
CNT_W, 5, main counter width; expire period is (period+1) ticks

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command this cycle
cmd_op  input  2  00 LOAD, 01 START, 10 STOP, 11 CLEAR
cmd_prescale  input  PRE_W  prescale limit; used by LOAD only
cmd_period  input  CNT_W  period limit; used by LOAD only
cmd_oneshot  input  1  1 = one-shot, 0 = periodic; used by LOAD only
cmd_err  output  1  registered 1-cycle pulse: the accepted command was illegal in the current state
tick  output  1  registered 1-cycle pulse on each prescaler wrap
expire  output  1  registered 1-cycle pulse on each main-counter wrap
count  output  CNT_W  current main counter value
busy  output  1  state is ARM or RUN

Behaviour:
- Handshake: a command is accepted when cmd_valid && cmd_ready at a rising edge. cmd_ready = (state != ARM). cmd_ready does not depend on cmd_valid or cmd_op.
- States: IDLE, ARM, RUN, PAUSED, DONE.
- CLEAR, any state: go to IDLE; clear pre_cnt and count; config registers unchanged; tick and expire suppressed that cycle; no error.
- LOAD in IDLE, PAUSED or DONE: latch prescale, period and oneshot; clear pre_cnt and count; go to IDLE.
- LOAD in RUN: ignored; cmd_err pulse.
- START in IDLE or DONE: clear counters; go to ARM.
- START in PAUSED: keep counters; go to ARM.
- START in RUN: ignored; cmd_err pulse.
- STOP in RUN: go to PAUSED; counters hold.
- STOP in any state other than RUN: ignored; cmd_err pulse.
- ARM lasts exactly one cycle, then moves to RUN. This gives a fixed one-cycle start latency.
- RUN step, evaluated every RUN cycle:
  - If pre_cnt == prescale_q: pre_cnt becomes 0 and a tick is produced. Otherwise pre_cnt increments.
  - On a tick, if count == period_q: count becomes 0 and an expire is produced; in one-shot mode state moves to DONE. Otherwise count increments.
- Pulse timing: tick and expire are registered, so they are high in the cycle after the edge on which the wrap occurs.
- Timing formula: with the START accepted at edge E0, the first expire is registered at edge E(1+(P+1)(N+1)), where P = prescale and N = period. Expires then repeat every (P+1)(N+1) cycles.
- Simultaneous STOP and RUN step: the step still executes, including any tick or expire, then state goes to PAUSED. If a one-shot expire occurs on that same edge, DONE takes priority over PAUSED; the STOP is still accepted without cmd_err.
- Widths: comparisons are equality only, so counters never exceed their limits. prescale 0 gives a tick every RUN cycle. period 0 gives an expire on every tick.
- Idle outputs: in IDLE, PAUSED and DONE no ticks or expires are produced; count holds.
- Reset (asynchronous assert, any time including mid-RUN):
  - state becomes IDLE; pre_cnt, count, prescale_q and period_q become 0; oneshot_q becomes 0 (periodic).
  - outputs: tick=0, expire=0, cmd_err=0, busy=0, cmd_ready=1.
  - Deassertion is assumed synchronised externally.

Decomposition:
- Package cascade_timer_pkg holds:
  - the cmd_op enum (OP_LOAD, OP_START, OP_STOP, OP_CLEAR);
  - the state enum;
  - default width constants PRE_W_DEF=5 and CNT_W_DEF=5.
- Sub-module timer_stage: a parameterised wrap counter with ports enable, clear, limit, value and wrap. It is instantiated twice, as prescaler and main stage; wrap of the prescaler drives enable of the main stage. The FSM, handshake and output pulse registers live in cascade_timer_ctrl.

Test Plan:
- Reset, then START only (config 0/0, periodic) -> after ARM, tick and expire high every cycle; count stays 0; cmd_err never asserts.
- LOAD P=1 N=3 periodic, then START at E0 -> tick at E3, E5, E7, E9; expire at E9, E17, E25; count sequence 0,1,2,3,0.
- LOAD P=0 N=2 one-shot, START -> exactly one expire, at E4; then state DONE, busy=0, count=0; a further START rearms and gives an expire again 3 cycles after RUN entry.
- In RUN, STOP at count=2 -> PAUSED, count holds at 2. START -> resumes from 2 after the 1-cycle ARM. LOAD or START issued while RUN -> cmd_err pulse, config unchanged.
- cmd_ready low exactly in the ARM cycle; a command held valid through ARM is accepted on the next edge. CLEAR issued on the same edge as an expire -> expire suppressed, IDLE, count=0.
- Assert reset mid-RUN with count=3 -> all outputs go to reset values immediately (asynchronously); after release, the state is IDLE and the config registers are 0.

Source files
------------

// File: rtl/cascade_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cascade_timer_pkg
//  Description : Shared types and default widths for the cascaded timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cascade_timer_pkg;

    localparam int PRE_W_DEF = 5;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_START = 2'b01,
        OP_STOP  = 2'b10,
        OP_CLEAR = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/timer_stage.sv
`default_nettype none
// ============================================================================
//  Module      : timer_stage
//  Description : Wrap counter: counts enabled cycles from 0 up to limit, then
//                wraps to 0; wrap is the combinational wrap-this-cycle flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_stage
    import cascade_timer_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic [W-1:0] value,
    output logic         wrap
);

    logic [W-1:0] r_value;

    // Equality compare only: the counter can never run past its limit.
    assign wrap  = enable && (r_value == limit);
    assign value = r_value;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_value <= '0;
        end else if (clear) begin
            r_value <= '0;
        end else if (enable) begin
            r_value <= wrap ? '0 : r_value + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cascade_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cascade_timer_ctrl
//  Description : Command-driven controller for a prescaler + period counter
//                cascade producing tick / expire pulses, one-shot or periodic.
//  Revision    : 1.0 - initial release
// ============================================================================
module cascade_timer_ctrl
    import cascade_timer_pkg::*;
#(
    parameter int PRE_W = PRE_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [PRE_W-1:0] cmd_prescale,
    input  logic [CNT_W-1:0] cmd_period,
    input  logic             cmd_oneshot,
    output logic             cmd_err,
    output logic             tick,
    output logic             expire,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    state_e           r_state;
    logic [PRE_W-1:0] r_prescale;
    logic [CNT_W-1:0] r_period;
    logic             r_oneshot;
    logic             r_tick;
    logic             r_expire;
    logic             r_cmd_err;

    cmd_op_e          w_op;
    logic             w_accept;
    logic             w_step;
    logic             w_clr;
    logic             w_pre_wrap;
    logic             w_main_wrap;
    logic             w_oneshot_end;
    logic [PRE_W-1:0] w_pre_cnt_unused;
    logic [CNT_W-1:0] w_count;

    assign w_op     = cmd_op_e'(cmd_op);
    assign w_accept = cmd_valid && cmd_ready;

    // The RUN step only yields to CLEAR; illegal LOAD/START and STOP still step.
    assign w_step = (r_state == ST_RUN) && !(w_accept && (w_op == OP_CLEAR));

    assign w_clr = w_accept &&
                   ((w_op == OP_CLEAR) ||
                    ((w_op == OP_LOAD)  && (r_state != ST_RUN)) ||
                    ((w_op == OP_START) && ((r_state == ST_IDLE) || (r_state == ST_DONE))));

    assign w_oneshot_end = w_main_wrap && r_oneshot;

    timer_stage #(.W(PRE_W)) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (w_step),
        .clear  (w_clr),
        .limit  (r_prescale),
        .value  (w_pre_cnt_unused),
        .wrap   (w_pre_wrap)
    );

    timer_stage #(.W(CNT_W)) u_main (
        .clock  (clock),
        .reset  (reset),
        .enable (w_pre_wrap),
        .clear  (w_clr),
        .limit  (r_period),
        .value  (w_count),
        .wrap   (w_main_wrap)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_prescale <= '0;
            r_period   <= '0;
            r_oneshot  <= 1'b0;
            r_tick     <= 1'b0;
            r_expire   <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_tick    <= w_pre_wrap;
            r_expire  <= w_main_wrap;
            r_cmd_err <= 1'b0;

            case (r_state)
                ST_ARM:  r_state <= ST_RUN;
                ST_RUN:  if (w_oneshot_end) r_state <= ST_DONE;
                default: ;
            endcase

            if (w_accept) begin
                unique case (w_op)
                    OP_CLEAR: r_state <= ST_IDLE;
                    OP_LOAD: begin
                        if (r_state == ST_RUN) begin
                            r_cmd_err <= 1'b1;
                        end else begin
                            r_prescale <= cmd_prescale;
                            r_period   <= cmd_period;
                            r_oneshot  <= cmd_oneshot;
                            r_state    <= ST_IDLE;
                        end
                    end
                    OP_START: begin
                        if (r_state == ST_RUN) r_cmd_err <= 1'b1;
                        else                   r_state   <= ST_ARM;
                    end
                    OP_STOP: begin
                        // A one-shot finishing on this edge wins over the pause.
                        if (r_state == ST_RUN) begin
                            if (!w_oneshot_end) r_state <= ST_PAUSED;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign cmd_ready = (r_state != ST_ARM);
    assign busy      = (r_state == ST_ARM) || (r_state == ST_RUN);
    assign cmd_err   = r_cmd_err;
    assign tick      = r_tick;
    assign expire    = r_expire;
    assign count     = w_count;

endmodule
`default_nettype wire
